// File: rtl/apb_uart_host_if.sv
// ---------------------------------------------------------------------------
// apb_uart_host_if : APB bus between the UART host sequencer and apb_slave
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface apb_uart_host_if;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [2:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pslverr
    );
endinterface

`default_nettype wire

// File: rtl/apb_uart_host.sv
// ---------------------------------------------------------------------------
// apb_uart_host : APB master that configures the UART block, polls for RX data
//                 and presents each received byte on a valid/ready stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_uart_host #(
    parameter int POLL_GAP = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        cfg_start,
    input  wire logic        cfg_stop,
    input  wire logic [13:0] cfg_bit_per,
    input  wire logic [3:0]  cfg_dsize,
    output      logic        busy,
    output      logic [7:0]  rx_byte,
    output      logic [1:0]  rx_err,
    output      logic        rx_valid,
    input  wire logic        rx_ready,
    output      logic        slv_err,
    apb_uart_host_if.master  bus
);

    localparam int c_cnt_w = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);

    localparam logic [2:0] c_addr_dsr   = 3'd0;
    localparam logic [2:0] c_addr_esr   = 3'd1;
    localparam logic [2:0] c_addr_bp_lo = 3'd2;
    localparam logic [2:0] c_addr_bp_hi = 3'd3;
    localparam logic [2:0] c_addr_dsize = 3'd4;
    localparam logic [2:0] c_addr_rxd   = 3'd6;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_WR_BP0 = 4'd1,
        S_WR_BP1 = 4'd2,
        S_WR_DS  = 4'd3,
        S_RD_SR  = 4'd4,
        S_RD_ERR = 4'd5,
        S_RD_RX  = 4'd6,
        S_HOLD   = 4'd7,
        S_GAP    = 4'd8
    } state_t;

    // With no gap configured the next poll follows the previous one directly.
    localparam state_t c_poll_next = (POLL_GAP == 0) ? S_RD_SR : S_GAP;

    state_t               state_q, state_d;
    logic                 access_q, access_d;
    logic                 stop_pend_q, stop_pend_d;
    logic [13:0]          bp_q, bp_d;
    logic [3:0]           ds_q, ds_d;
    logic [c_cnt_w-1:0]   cnt_q, cnt_d;
    logic                 psel_q, psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q, pwrite_d;
    logic [2:0]           paddr_q, paddr_d;
    logic [7:0]           pwdata_q, pwdata_d;
    logic [7:0]           rx_byte_q, rx_byte_d;
    logic [1:0]           rx_err_q, rx_err_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 slv_err_q, slv_err_d;
    logic                 busy_q, busy_d;
    logic                 w_stop;

    // A stop pulse arriving mid-transfer is remembered until the next boundary.
    assign w_stop = stop_pend_q | cfg_stop;

    always_comb begin
        state_d    = state_q;
        access_d   = access_q;
        bp_d       = bp_q;
        ds_d       = ds_q;
        cnt_d      = cnt_q;
        rx_byte_d  = rx_byte_q;
        rx_err_d   = rx_err_q;
        rx_valid_d = rx_valid_q;
        slv_err_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    bp_d     = cfg_bit_per;
                    ds_d     = cfg_dsize;
                    access_d = 1'b0;
                    state_d  = S_WR_BP0;
                end
            end
            S_WR_BP0, S_WR_BP1, S_WR_DS, S_RD_SR, S_RD_ERR, S_RD_RX: begin
                if (!access_q) begin
                    access_d = 1'b1;
                end else begin
                    access_d = 1'b0;
                    if (bus.pslverr) begin
                        slv_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end else if (w_stop) begin
                        state_d = S_IDLE;
                    end else begin
                        case (state_q)
                            S_WR_BP0: state_d = S_WR_BP1;
                            S_WR_BP1: state_d = S_WR_DS;
                            S_WR_DS:  state_d = S_RD_SR;
                            S_RD_SR:  state_d = bus.prdata[0] ? S_RD_ERR : c_poll_next;
                            S_RD_ERR: begin
                                rx_err_d = bus.prdata[1:0];
                                state_d  = S_RD_RX;
                            end
                            S_RD_RX: begin
                                rx_byte_d  = bus.prdata;
                                rx_valid_d = 1'b1;
                                state_d    = S_HOLD;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            S_HOLD: begin
                if (w_stop) begin
                    rx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    state_d    = c_poll_next;
                end
            end
            S_GAP: begin
                if (w_stop) begin
                    state_d = S_IDLE;
                end else if (cnt_q == c_gap_last) begin
                    state_d = S_RD_SR;
                end else begin
                    cnt_d = cnt_q + c_cnt_w'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if ((state_d == S_GAP) && (state_q != S_GAP)) begin
            cnt_d = '0;
        end

        stop_pend_d = (state_d == S_IDLE) ? 1'b0 : (stop_pend_q | cfg_stop);

        // Bus outputs are decoded from the next state so they leave the flops aligned.
        psel_d   = 1'b0;
        pwrite_d = 1'b0;
        paddr_d  = 3'd0;
        pwdata_d = 8'd0;
        case (state_d)
            S_WR_BP0: begin
                psel_d = 1'b1; pwrite_d = 1'b1; paddr_d = c_addr_bp_lo; pwdata_d = bp_d[7:0];
            end
            S_WR_BP1: begin
                psel_d = 1'b1; pwrite_d = 1'b1; paddr_d = c_addr_bp_hi; pwdata_d = {2'b00, bp_d[13:8]};
            end
            S_WR_DS: begin
                psel_d = 1'b1; pwrite_d = 1'b1; paddr_d = c_addr_dsize; pwdata_d = {4'b0000, ds_d};
            end
            S_RD_SR:  begin psel_d = 1'b1; paddr_d = c_addr_dsr; end
            S_RD_ERR: begin psel_d = 1'b1; paddr_d = c_addr_esr; end
            S_RD_RX:  begin psel_d = 1'b1; paddr_d = c_addr_rxd; end
            default: ;
        endcase
        penable_d = psel_d & access_d;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            access_q    <= 1'b0;
            stop_pend_q <= 1'b0;
            bp_q        <= 14'd0;
            ds_q        <= 4'd0;
            cnt_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= 3'd0;
            pwdata_q    <= 8'd0;
            rx_byte_q   <= 8'd0;
            rx_err_q    <= 2'd0;
            rx_valid_q  <= 1'b0;
            slv_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            access_q    <= access_d;
            stop_pend_q <= stop_pend_d;
            bp_q        <= bp_d;
            ds_q        <= ds_d;
            cnt_q       <= cnt_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rx_byte_q   <= rx_byte_d;
            rx_err_q    <= rx_err_d;
            rx_valid_q  <= rx_valid_d;
            slv_err_q   <= slv_err_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.paddr   = paddr_q;
    assign bus.pwdata  = pwdata_q;
    assign busy        = busy_q;
    assign rx_byte     = rx_byte_q;
    assign rx_err      = rx_err_q;
    assign rx_valid    = rx_valid_q;
    assign slv_err     = slv_err_q;

endmodule

`default_nettype wire
